// File: rtl/sram1rw_arb2.sv
// sram1rw_arb2 -- sequencer and two-port arbiter for one SRAM1RW256x8 single-port macro.
// After reset it zero-fills the array (INIT). It then shares the macro between port 0 and
// port 1 using a valid/ready handshake (RUN). Read data returns on one shared response channel.
// Latency: a read accepted at edge T is read by the macro at T+1 and reported after edge T+2.
// Backpressure: ready is combinational from valid; the response channel has no backpressure.
//
// Ports:
//   clk, rst_n            clock (also the macro CE) and async active-low reset
//   p0_*/p1_*             request channels: valid, ready, we, addr, wdata
//   rsp_valid/port/data   one-cycle read response tagged with the originating port
//   init_done             zero-fill complete; requests may be accepted
//   sram_a/csb/web/oeb/i  registered drive to the macro (control pins active-low)
//   sram_o                macro read data
//
// Build option: define SRAM_ARB_FIXED_PRIO_EN to give port 0 fixed priority on ties.
// Port 1 can then starve. By default the two ports alternate on ties (round-robin).

module sram1rw_arb2 #(
   parameter int            AW         = 8,
   parameter int            DW         = 8,
   parameter logic [DW-1:0] INIT_VALUE = '0
) (
   input  logic          clk,
   input  logic          rst_n,

   input  logic          p0_valid,
   output logic          p0_ready,
   input  logic          p0_we,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,

   input  logic          p1_valid,
   output logic          p1_ready,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,

   output logic          rsp_valid,
   output logic          rsp_port,
   output logic [DW-1:0] rsp_data,

   output logic          init_done,

   output logic [AW-1:0] sram_a,
   output logic          sram_csb,
   output logic          sram_web,
   output logic          sram_oeb,
   output logic [DW-1:0] sram_i,
   input  logic [DW-1:0] sram_o
);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] cnt, cnt_nxt;

   // Next values for the registered macro drive
   logic          csb_nxt, web_nxt;
   logic [AW-1:0] a_nxt;
   logic [DW-1:0] i_nxt;

   // Read pipeline: stage 1 = macro command cycle, stage 2 = macro output cycle
   logic          s1_rd, s1_rd_nxt;
   logic          s1_port, s1_port_nxt;
   logic          s2_port;

   logic          grant0, grant1;

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
`ifdef SRAM_ARB_FIXED_PRIO_EN
   assign grant0 = p0_valid;
   assign grant1 = p1_valid & ~p0_valid;
`else
   // Port that won the most recent accepted transfer. The reset value is 1,
   // so port 0 takes the first tie.
   logic last_grant;

   assign grant0 = p0_valid & (~p1_valid |  last_grant);
   assign grant1 = p1_valid & (~p0_valid | ~last_grant);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (p1_ready) begin
         last_grant <= 1'b1;
      end else if (p0_ready) begin
         last_grant <= 1'b0;
      end
   end
`endif

   // ------------------------------------------------------------------
   // FSM: next state, handshake and next macro command
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      csb_nxt     = 1'b1;
      web_nxt     = 1'b1;
      a_nxt       = sram_a;   // address and data hold while idle
      i_nxt       = sram_i;
      s1_rd_nxt   = 1'b0;
      s1_port_nxt = s1_port;
      p0_ready    = 1'b0;
      p1_ready    = 1'b0;

      case (state)
         ST_INIT: begin
            csb_nxt = 1'b0;
            web_nxt = 1'b0;
            a_nxt   = cnt;
            i_nxt   = INIT_VALUE;
            cnt_nxt = cnt + AW'(1);
            // The last address is issued on this edge, so RUN starts right after it.
            if (cnt == {AW{1'b1}}) begin
               state_nxt = ST_RUN;
            end
         end

         ST_RUN: begin
            p0_ready = grant0;
            p1_ready = grant1;
            if (grant0) begin
               csb_nxt     = 1'b0;
               web_nxt     = ~p0_we;
               a_nxt       = p0_addr;
               i_nxt       = p0_wdata;
               s1_rd_nxt   = ~p0_we;
               s1_port_nxt = 1'b0;
            end else if (grant1) begin
               csb_nxt     = 1'b0;
               web_nxt     = ~p1_we;
               a_nxt       = p1_addr;
               i_nxt       = p1_wdata;
               s1_rd_nxt   = ~p1_we;
               s1_port_nxt = 1'b1;
            end
         end

         default: begin
            state_nxt = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign init_done = (state == ST_RUN);

   // ------------------------------------------------------------------
   // Macro command register (stage 1)
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sram_csb <= 1'b1;
         sram_web <= 1'b1;
         sram_a   <= '0;
         sram_i   <= '0;
         s1_rd    <= 1'b0;
         s1_port  <= 1'b0;
      end else begin
         sram_csb <= csb_nxt;
         sram_web <= web_nxt;
         sram_a   <= a_nxt;
         sram_i   <= i_nxt;
         s1_rd    <= s1_rd_nxt;
         s1_port  <= s1_port_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Read return: stage 2 enables the macro output, then the data is captured.
   // An asynchronous reset clears every stage, so an in-flight read never responds.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sram_oeb  <= 1'b1;
         s2_port   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_port  <= 1'b0;
         rsp_data  <= '0;
      end else begin
         sram_oeb  <= ~s1_rd;
         s2_port   <= s1_port;
         rsp_valid <= ~sram_oeb;
         if (!sram_oeb) begin
            rsp_port <= s2_port;
            rsp_data <= sram_o;
         end
      end
   end

endmodule
